bram_snapshot_ctrl: RTL and testbench

- Fabric-side capture sequencer for the FPGA port of the dual-port AXI-lite-readable BRAM.
- Once armed, streams samples into the BRAM as a ring buffer, so pre-trigger history is retained.
- On a trigger, writes a programmed number of post-trigger samples, then stops and flags done.
- Software reads the RAM over AXI-lite, using trig_addr and wrapped to unroll the ring.

---
 rtl/bram_snapshot_pkg.sv | 20 ++
 rtl/bram_snapshot_ctrl_wr_ptr.sv | 47 ++++
 rtl/bram_snapshot_ctrl.sv | 157 +++++++++++++++
 tb/tb_bram_snapshot_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_snapshot_pkg.sv
// -----------------------------------------------------------------------------
// bram_snapshot_pkg
// Shared definitions for the BRAM snapshot capture sequencer: the FSM state
// encoding and a small decode helper used for the busy flag.
// -----------------------------------------------------------------------------
package bram_snapshot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // True in the two states where samples are being streamed into the ring.
  function automatic logic is_busy(input state_e s);
    return (s == ST_ARMED) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/bram_snapshot_ctrl_wr_ptr.sv
// -----------------------------------------------------------------------------
// snapshot_wr_ptr
// Ring-buffer write pointer with wrap detection.
//   clk_i      : clock
//   rst_n_i    : asynchronous active-low reset
//   clr_i      : synchronous clear of pointer and wrapped flag (new capture)
//   en_i       : advance pointer by one slot (a sample is being written)
//   wp_o       : current write pointer (address for the next write)
//   wrapped_o  : sticky, set once the pointer has rolled over from max to 0
// -----------------------------------------------------------------------------
module snapshot_wr_ptr #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  output logic [ADDR_WIDTH-1:0] wp_o,
  output logic                  wrapped_o
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = {ADDR_WIDTH{1'b1}};

  logic [ADDR_WIDTH-1:0] wp_q;
  logic                  wrapped_q;

  // Pointer advance with modulo rollover; wrapped latches on the rollover.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp_q      <= {ADDR_WIDTH{1'b0}};
      wrapped_q <= 1'b0;
    end else if (clr_i) begin
      wp_q      <= {ADDR_WIDTH{1'b0}};
      wrapped_q <= 1'b0;
    end else if (en_i) begin
      wp_q <= wp_q + PTR_ONE;
      if (wp_q == PTR_MAX) begin
        wrapped_q <= 1'b1;
      end
    end
  end

  assign wp_o      = wp_q;
  assign wrapped_o = wrapped_q;

endmodule

// File: rtl/bram_snapshot_ctrl.sv
// -----------------------------------------------------------------------------
// bram_snapshot_ctrl
// Fabric-side capture sequencer for the FPGA port of a dual-port BRAM. Once
// armed, valid samples are streamed into the BRAM as a ring so pre-trigger
// history is retained. A qualified trigger records its slot address and then
// a programmed number of post-trigger samples are written before stopping.
//   fpga_clk     : clock
//   rst_n        : asynchronous active-low reset
//   arm          : start/restart capture (accepted in IDLE and DONE)
//   abort        : return to IDLE from any state (highest priority)
//   trigger      : level trigger, qualified by din_valid while ARMED
//   post_samples : samples written after the trigger sample (sampled at trigger)
//   din/din_valid: sample stream
//   bram_addr/bram_din/bram_we : registered BRAM write port
//   busy         : ARMED or CAPTURE
//   done         : DONE
//   trig_addr    : BRAM slot holding the trigger sample
//   wrapped      : every ring slot has been written since arm
// -----------------------------------------------------------------------------
module bram_snapshot_ctrl
  import bram_snapshot_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  fpga_clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] post_samples,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  wrapped
);

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] trig_addr_q;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [DATA_WIDTH-1:0] bram_din_q;
  logic                  bram_we_q;

  logic                  wr_en_d;
  logic                  arm_take_d;
  logic [ADDR_WIDTH-1:0] wp_s;
  logic                  wrapped_s;

  // Qualify the write strobe and arm acceptance against state and abort.
  always_comb begin
    wr_en_d    = 1'b0;
    arm_take_d = 1'b0;
    if (abort) begin
      wr_en_d    = 1'b0;
      arm_take_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          arm_take_d = arm;
          wr_en_d    = 1'b0;
        end
        ST_ARMED, ST_CAPTURE: begin
          // arm is ignored here, so data proceeds even when arm is high
          arm_take_d = 1'b0;
          wr_en_d    = din_valid;
        end
        default: begin
          arm_take_d = 1'b0;
          wr_en_d    = 1'b0;
        end
      endcase
    end
  end

  snapshot_wr_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk_i     (fpga_clk),
    .rst_n_i   (rst_n),
    .clr_i     (arm_take_d),
    .en_i      (wr_en_d),
    .wp_o      (wp_s),
    .wrapped_o (wrapped_s)
  );

  // Capture FSM, post-trigger counter and registered BRAM write port.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      trig_addr_q <= {ADDR_WIDTH{1'b0}};
      bram_addr_q <= {ADDR_WIDTH{1'b0}};
      bram_din_q  <= {DATA_WIDTH{1'b0}};
      bram_we_q   <= 1'b0;
    end else begin
      bram_we_q <= wr_en_d;
      if (wr_en_d) begin
        bram_addr_q <= wp_s;
        bram_din_q  <= din;
      end

      if (abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm) begin
              state_q <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (wr_en_d && trigger) begin
              trig_addr_q <= wp_s;
              cnt_q       <= post_samples;
              state_q     <= (post_samples == CNT_ZERO) ? ST_DONE : ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            // cnt counts the post-trigger samples still to be written
            if (wr_en_d) begin
              cnt_q <= cnt_q - CNT_ONE;
              if (cnt_q == CNT_ONE) begin
                state_q <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            if (arm) begin
              state_q <= ST_ARMED;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign bram_we   = bram_we_q;
  assign busy      = is_busy(state_q);
  assign done      = (state_q == ST_DONE);
  assign trig_addr = trig_addr_q;
  assign wrapped   = wrapped_s;

endmodule

// File: tb/tb_bram_snapshot_ctrl.sv
module tb_bram_snapshot_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          fpga_clk = 1'b0;
  logic          rst_n;
  logic          arm, abort, trigger, din_valid;
  logic [AW-1:0] post_samples;
  logic [DW-1:0] din;
  logic [AW-1:0] bram_addr, trig_addr;
  logic [DW-1:0] bram_din;
  logic          bram_we, busy, done, wrapped;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;

  bram_snapshot_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .fpga_clk     (fpga_clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .abort        (abort),
    .trigger      (trigger),
    .post_samples (post_samples),
    .din          (din),
    .din_valid    (din_valid),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din),
    .bram_we      (bram_we),
    .busy         (busy),
    .done         (done),
    .trig_addr    (trig_addr),
    .wrapped      (wrapped)
  );

  always #5 fpga_clk = ~fpga_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1);
  end

  // ---------------- reference model (sample-count view of the capture) ------
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2, M_DONE = 3;
  int            m_mode, m_n, m_left;
  logic          m_we, m_wrapped;
  logic [AW-1:0] m_addr, m_trig;
  logic [DW-1:0] m_din;

  task automatic model_reset();
    m_mode = M_IDLE; m_n = 0; m_left = 0;
    m_we = 1'b0; m_wrapped = 1'b0; m_addr = '0; m_trig = '0; m_din = '0;
  endtask

  task automatic model_update(input logic a, ab, tr, v, input logic [DW-1:0] d,
                              input logic [AW-1:0] p);
    m_we = 1'b0;
    if (ab) begin
      m_mode = M_IDLE;
    end else if (a && (m_mode == M_IDLE || m_mode == M_DONE)) begin
      m_mode = M_ARMED; m_n = 0; m_wrapped = 1'b0;
    end else if ((m_mode == M_ARMED || m_mode == M_CAPT) && v) begin
      m_we   = 1'b1;
      m_addr = AW'(m_n % DEPTH);
      m_din  = d;
      if (m_mode == M_ARMED && tr) begin
        m_trig = AW'(m_n % DEPTH);
        m_left = int'(p);
        m_mode = (p == 0) ? M_DONE : M_CAPT;
      end else if (m_mode == M_CAPT) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = M_DONE;
      end
      m_n = m_n + 1;
      if (m_n >= DEPTH) m_wrapped = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model_we", 32'(bram_we), 32'(m_we));
    if (m_we) begin
      chk("model_addr", 32'(bram_addr), 32'(m_addr));
      chk("model_din", 32'(bram_din), 32'(m_din));
    end
    chk("model_busy", 32'(busy), 32'(m_mode == M_ARMED || m_mode == M_CAPT));
    chk("model_done", 32'(done), 32'(m_mode == M_DONE));
    chk("model_trig", 32'(trig_addr), 32'(m_trig));
    chk("model_wrapped", 32'(wrapped), 32'(m_wrapped));
  endtask

  task automatic step(input logic a, ab, tr, v, input logic [DW-1:0] d,
                      input logic [AW-1:0] p);
    @(negedge fpga_clk);
    arm = a; abort = ab; trigger = tr; din_valid = v; din = d; post_samples = p;
    @(posedge fpga_clk);
    #1;
    model_update(a, ab, tr, v, d, p);
    chk_model();
    if (bram_we) we_cnt++;
  endtask

  task automatic do_reset();
    @(negedge fpga_clk);
    rst_n = 1'b0;
    arm = 0; abort = 0; trigger = 0; din_valid = 0; din = '0; post_samples = '0;
    @(negedge fpga_clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- table-driven vectors ------------------------------------
  typedef struct {
    logic          arm, abort, trig, valid;
    logic [DW-1:0] din;
    logic [AW-1:0] post;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          e_busy, e_done;
    logic [AW-1:0] e_trig;
    logic          e_wrapped;
  } vec_t;

  function automatic vec_t mk(logic a, ab, tr, v, logic [DW-1:0] d, logic [AW-1:0] p,
                              logic we, logic [AW-1:0] ad, logic [DW-1:0] ed,
                              logic bz, dn, logic [AW-1:0] tg, logic wr);
    vec_t r;
    r.arm = a; r.abort = ab; r.trig = tr; r.valid = v; r.din = d; r.post = p;
    r.e_we = we; r.e_addr = ad; r.e_din = ed; r.e_busy = bz; r.e_done = dn;
    r.e_trig = tg; r.e_wrapped = wr;
    return r;
  endfunction

  vec_t vecs[9];

  initial begin
    // No-wrap capture, post_samples=3, trigger on 0xA2 (third sample).
    vecs[0] = mk(1,0,0,0, 16'h0000, 4'd3, 0, 4'd0, 16'h0000, 1, 0, 4'd0, 0);
    vecs[1] = mk(0,0,0,1, 16'h00A0, 4'd3, 1, 4'd0, 16'h00A0, 1, 0, 4'd0, 0);
    vecs[2] = mk(0,0,0,1, 16'h00A1, 4'd3, 1, 4'd1, 16'h00A1, 1, 0, 4'd0, 0);
    vecs[3] = mk(0,0,1,1, 16'h00A2, 4'd3, 1, 4'd2, 16'h00A2, 1, 0, 4'd2, 0);
    vecs[4] = mk(0,0,0,1, 16'h00A3, 4'd9, 1, 4'd3, 16'h00A3, 1, 0, 4'd2, 0);
    vecs[5] = mk(0,0,1,1, 16'h00A4, 4'd3, 1, 4'd4, 16'h00A4, 1, 0, 4'd2, 0);
    vecs[6] = mk(0,0,0,1, 16'h00A5, 4'd3, 1, 4'd5, 16'h00A5, 0, 1, 4'd2, 0);
    vecs[7] = mk(0,0,0,0, 16'h0000, 4'd3, 0, 4'd5, 16'h00A5, 0, 1, 4'd2, 0);
    vecs[8] = mk(0,0,1,1, 16'h00EE, 4'd3, 0, 4'd5, 16'h00A5, 0, 1, 4'd2, 0);

    rst_n = 1'b0;
    arm = 0; abort = 0; trigger = 0; din_valid = 0; din = '0; post_samples = '0;
    model_reset();
    repeat (2) @(negedge fpga_clk);
    chk("rst_we", 32'(bram_we), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_din", 32'(bram_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_trig", 32'(trig_addr), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    rst_n = 1'b1;

    // Table: check against both fixed expectations and the model.
    we_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].arm, vecs[i].abort, vecs[i].trig, vecs[i].valid, vecs[i].din, vecs[i].post);
      chk($sformatf("vec%0d_we", i), 32'(bram_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d_addr", i), 32'(bram_addr), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d_din", i), 32'(bram_din), 32'(vecs[i].e_din));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d_trig", i), 32'(trig_addr), 32'(vecs[i].e_trig));
      chk($sformatf("vec%0d_wrapped", i), 32'(wrapped), 32'(vecs[i].e_wrapped));
    end
    chk("nowrap_we_pulses", 32'(we_cnt), 32'd6);

    // Wrap: post=0, 18 samples, trigger on the 18th -> addr 0..15,0,1.
    step(1,0,0,0, 16'h0, 4'd0);
    for (int i = 0; i < 18; i++) begin
      step(0,0,(i == 17),1, 16'(16'h0100 + i), 4'd0);
      chk($sformatf("wrap_addr%0d", i), 32'(bram_addr), 32'(i % 16));
    end
    chk("wrap_wrapped", 32'(wrapped), 32'd1);
    chk("wrap_trig", 32'(trig_addr), 32'd1);
    chk("wrap_done", 32'(done), 32'd1);

    // Trigger on the wrap cycle: trig_addr=max and wrapped=1 together.
    step(1,0,0,0, 16'h0, 4'd0);
    for (int i = 0; i < 16; i++) step(0,0,(i == 15),1, 16'(16'h0200 + i), 4'd0);
    chk("wrapcyc_trig", 32'(trig_addr), 32'd15);
    chk("wrapcyc_wrapped", 32'(wrapped), 32'd1);
    chk("wrapcyc_done", 32'(done), 32'd1);

    // post_samples = max: whole ring except trigger slot rewritten.
    step(1,0,0,0, 16'h0, 4'd0);
    step(0,0,1,1, 16'h0300, 4'd15);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("postmax_notdone%0d", i), 32'(done), 32'd0);
      step(0,0,0,1, 16'(16'h0301 + i), 4'd0);
    end
    chk("postmax_done", 32'(done), 32'd1);
    chk("postmax_last_addr", 32'(bram_addr), 32'd15);

    // Gapped valid in CAPTURE, post=2.
    step(1,0,0,0, 16'h0, 4'd2);
    step(0,0,1,1, 16'h0400, 4'd2);
    step(0,0,0,0, 16'h0401, 4'd2);
    chk("gap_we_low", 32'(bram_we), 32'd0);
    step(0,0,0,1, 16'h0402, 4'd2);
    chk("gap_we_high", 32'(bram_we), 32'd1);
    chk("gap_notdone", 32'(done), 32'd0);
    step(0,0,0,0, 16'h0403, 4'd2);
    chk("gap_notdone2", 32'(done), 32'd0);
    step(0,0,0,1, 16'h0404, 4'd2);
    chk("gap_done", 32'(done), 32'd1);

    // Simultaneous events.
    step(0,1,0,0, 16'h0, 4'd0);           // abort from DONE -> IDLE
    step(1,0,1,1, 16'h0500, 4'd0);        // arm+trigger in IDLE
    chk("armtrig_busy", 32'(busy), 32'd1);
    chk("armtrig_we", 32'(bram_we), 32'd0);
    step(0,0,1,0, 16'h0501, 4'd0);        // trigger without valid
    chk("trig_novalid_busy", 32'(busy), 32'd1);
    chk("trig_novalid_done", 32'(done), 32'd0);
    step(0,0,1,1, 16'h0502, 4'd4);        // real trigger -> CAPTURE
    step(1,1,0,1, 16'h0503, 4'd0);        // abort+arm in CAPTURE
    chk("abortarm_busy", 32'(busy), 32'd0);
    chk("abortarm_done", 32'(done), 32'd0);
    chk("abortarm_we", 32'(bram_we), 32'd0);
    step(0,0,0,1, 16'h0504, 4'd0);
    chk("idle_nowrite", 32'(bram_we), 32'd0);

    // Mid-capture asynchronous reset with cnt=5.
    step(1,0,0,0, 16'h0, 4'd5);
    step(0,0,0,1, 16'h0600, 4'd5);
    step(0,0,1,1, 16'h0601, 4'd5);
    @(negedge fpga_clk);
    din_valid = 1'b1; trigger = 1'b0; arm = 1'b0; abort = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(bram_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_trig", 32'(trig_addr), 32'd0);
    chk("midrst_addr", 32'(bram_addr), 32'd0);
    @(posedge fpga_clk);
    #1;
    chk("midrst_we_hold", 32'(bram_we), 32'd0);
    @(negedge fpga_clk);
    model_reset();
    rst_n = 1'b1;
    din_valid = 1'b0;
    step(1,0,0,0, 16'h0, 4'd0);
    step(0,0,0,1, 16'h0700, 4'd0);
    chk("rearm_addr0", 32'(bram_addr), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic          ra, rab, rt, rv;
      logic [AW-1:0] rp;
      ra  = ($urandom_range(0, 99) < 6);
      rab = ($urandom_range(0, 99) < 2);
      rt  = ($urandom_range(0, 99) < 8);
      rv  = ($urandom_range(0, 99) < 70);
      rp  = ($urandom_range(0, 9) == 0) ? 4'd15 : AW'($urandom_range(0, 6));
      step(ra, rab, rt, rv, 16'($urandom), rp);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
